// File: rtl/any1_icache_pkg.sv
// Shared types and constants for the ANY-1 L1 instruction cache fill controller.
package any1_icache_pkg;

    localparam int LINE_W    = 512;
    localparam int LINE_OFFS = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        WRITE  = 3'd2,
        SETTLE = 3'd3,
        INV    = 3'd4
    } ifill_state_t;

    localparam logic [2:0] FLT_NONE = 3'd0;
    localparam logic [2:0] FLT_BUS  = 3'd1;
    localparam logic [2:0] FLT_TMO  = 3'd2;

    // Beat counter width; a single-beat line still needs a 1-bit counter.
    function automatic int beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/any1_ifill_linebuf.sv
// Line assembly buffer: beat counter plus the 512-bit line register.
// Clear starts a new line, load writes the current beat's slice and advances,
// zero_rest wipes the current and all later slices after an aborted fill.
module any1_ifill_linebuf
    import any1_icache_pkg::*;
#(
    parameter int BUS_W = 128,
    localparam int BEATS  = LINE_W / BUS_W,
    localparam int BEAT_W = beat_w(LINE_W / BUS_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_ld,
    input  logic              i_zero_rest,
    input  logic [BUS_W-1:0]  i_dat,
    output logic [BEAT_W-1:0] o_beat,
    output logic              o_last,
    output logic [LINE_W-1:0] o_line
);

    logic [BEAT_W-1:0] r_beat;
    logic [LINE_W-1:0] r_line;

    // Beat counter and line slices; clear has priority over any beat activity.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_beat <= '0;
            r_line <= '0;
        end else if (i_zero_rest) begin
            for (int i = 0; i < BEATS; i++) begin
                if (i >= int'(r_beat)) begin
                    r_line[i*BUS_W +: BUS_W] <= '0;
                end
            end
        end else if (i_ld) begin
            r_line[int'(r_beat)*BUS_W +: BUS_W] <= i_dat;
            r_beat <= (r_beat == BEAT_W'(BEATS-1)) ? '0 : r_beat + BEAT_W'(1);
        end
    end

    assign o_beat = r_beat;
    assign o_last = (r_beat == BEAT_W'(BEATS-1));
    assign o_line = r_line;

endmodule

// File: rtl/any1_icache_fill_ctrl.sv
// Miss/fill and invalidate sequencer for the ANY-1 L1 instruction cache.
// Optional build macro ANY1_IFILL_TMO_EN adds a per-beat bus timeout that
// aborts the fill with fault code FLT_TMO.
//
//  state  | meaning
//  IDLE   | serve fetch, detect miss or invalidate request
//  FILL   | read line beats from the bus
//  WRITE  | one-cycle L1 tag write strobe
//  SETTLE | two cycles holding address/line while L1 writes data
//  INV    | one-cycle invalidate and acknowledge
module any1_icache_fill_ctrl
    import any1_icache_pkg::*;
#(
    parameter int AMSB    = 63,
    parameter int BUS_W   = 128,
    parameter int TMO_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_vld,
    input  logic [AMSB:0]     i_fetch_adr,
    output logic              o_fetch_rdy,
    input  logic              i_inv_req,
    input  logic              i_inv_all,
    input  logic [AMSB:0]     i_inv_adr,
    output logic              o_inv_ack,
    input  logic              i_ic_hit,
    output logic [AMSB:0]     o_ic_adr,
    output logic              o_ic_wr,
    output logic [LINE_W-1:0] o_ic_line,
    output logic [2:0]        o_ic_fault,
    output logic              o_ic_nxt,
    output logic              o_ic_invall,
    output logic              o_ic_invline,
    output logic              o_bus_cyc,
    output logic              o_bus_stb,
    output logic [AMSB:0]     o_bus_adr,
    input  logic              i_bus_ack,
    input  logic              i_bus_err,
    input  logic [BUS_W-1:0]  i_bus_dat
);

    localparam int BEATS  = LINE_W / BUS_W;
    localparam int BEAT_W = beat_w(BEATS);
    localparam int TMO_W  = $clog2(TMO_CYC + 1);

    ifill_state_t      r_state, w_nxt_state;
    logic [AMSB:0]     r_fill_adr;
    logic [2:0]        r_fault;
    logic              r_settle;

    logic              w_start;
    logic              w_ld;
    logic              w_zero;
    logic              w_tmo;
    logic              w_last;
    logic [BEAT_W-1:0] w_beat;
    logic [AMSB:0]     w_beat_off;

    any1_ifill_linebuf #(.BUS_W(BUS_W)) u_linebuf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_start),
        .i_ld        (w_ld),
        .i_zero_rest (w_zero),
        .i_dat       (i_bus_dat),
        .o_beat      (w_beat),
        .o_last      (w_last),
        .o_line      (o_ic_line)
    );

`ifdef ANY1_IFILL_TMO_EN
    logic [TMO_W-1:0] r_tmo_cnt;

    // Down-counter reloaded at fill start and on every accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (w_start || (r_state == FILL && i_bus_ack)) begin
            r_tmo_cnt <= TMO_W'(TMO_CYC - 1);
        end else if (r_state == FILL && r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        end
    end

    assign w_tmo = (r_state == FILL) && !i_bus_ack && !i_bus_err && (r_tmo_cnt == '0);
`else
    logic [TMO_W-1:0] w_unused_tmo;
    assign w_unused_tmo = TMO_W'(TMO_CYC);
    assign w_tmo        = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Fill address, fault code and settle phase tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fill_adr <= '0;
            r_fault    <= FLT_NONE;
            r_settle   <= 1'b0;
        end else begin
            if (w_start) begin
                r_fill_adr <= {i_fetch_adr[AMSB:LINE_OFFS], {LINE_OFFS{1'b0}}};
                r_fault    <= FLT_NONE;
            end else if (r_state == FILL && i_bus_err) begin
                r_fault    <= FLT_BUS;
            end else if (w_tmo) begin
                r_fault    <= FLT_TMO;
            end
            r_settle <= (r_state == SETTLE) && !r_settle;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_nxt_state  = r_state;
        w_start      = 1'b0;
        w_ld         = 1'b0;
        w_zero       = 1'b0;
        o_bus_cyc    = 1'b0;
        o_bus_stb    = 1'b0;
        o_ic_wr      = 1'b0;
        o_ic_nxt     = 1'b0;
        o_ic_invall  = 1'b0;
        o_ic_invline = 1'b0;
        o_inv_ack    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_inv_req) begin
                    w_nxt_state = INV;
                end else if (i_fetch_vld && !i_ic_hit) begin
                    w_start     = 1'b1;
                    w_nxt_state = FILL;
                end
            end
            FILL: begin
                o_bus_cyc = 1'b1;
                o_bus_stb = 1'b1;
                if (i_bus_err || w_tmo) begin
                    w_zero      = 1'b1;
                    w_nxt_state = WRITE;
                end else if (i_bus_ack) begin
                    w_ld = 1'b1;
                    if (w_last) begin
                        w_nxt_state = WRITE;
                    end
                end
            end
            WRITE: begin
                o_ic_wr     = 1'b1;
                o_ic_nxt    = 1'b1;
                w_nxt_state = SETTLE;
            end
            SETTLE: begin
                if (r_settle) begin
                    w_nxt_state = IDLE;
                end
            end
            INV: begin
                o_ic_invall  = i_inv_all;
                o_ic_invline = !i_inv_all;
                o_inv_ack    = 1'b1;
                w_nxt_state  = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // L1 address mux: fill line while writing it, invalidate target in INV, else fetch.
    always_comb begin
        case (r_state)
            FILL, WRITE, SETTLE: o_ic_adr = r_fill_adr;
            INV:                 o_ic_adr = i_inv_adr;
            default:             o_ic_adr = i_fetch_adr;
        endcase
    end

    assign w_beat_off  = (AMSB+1)'(w_beat) * (AMSB+1)'(BUS_W / 8);
    assign o_bus_adr   = r_fill_adr + w_beat_off;
    assign o_ic_fault  = r_fault;
    assign o_fetch_rdy = (r_state == IDLE) && i_fetch_vld && i_ic_hit && !i_inv_req;

endmodule

// File: tb/tb_any1_icache_fill_ctrl.sv
// Directed bench for the ANY-1 icache fill controller with a one-entry L1 tag model.
module tb_any1_icache_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_vld;
    logic [63:0]  fetch_adr;
    logic         fetch_rdy;
    logic         inv_req;
    logic         inv_all;
    logic [63:0]  inv_adr;
    logic         inv_ack;
    logic         ic_hit;
    logic [63:0]  ic_adr;
    logic         ic_wr;
    logic [511:0] ic_line;
    logic [2:0]   ic_fault;
    logic         ic_nxt;
    logic         ic_invall;
    logic         ic_invline;
    logic         bus_cyc;
    logic         bus_stb;
    logic [63:0]  bus_adr;
    logic         bus_ack;
    logic         bus_err;
    logic [127:0] bus_dat;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [511:0] exp_line;

    logic [57:0] m_tag = '0;
    logic        m_vld = 1'b0;

    always #5 clk = ~clk;

    any1_icache_fill_ctrl #(.AMSB(63), .BUS_W(128), .TMO_CYC(255)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fetch_vld  (fetch_vld),
        .i_fetch_adr  (fetch_adr),
        .o_fetch_rdy  (fetch_rdy),
        .i_inv_req    (inv_req),
        .i_inv_all    (inv_all),
        .i_inv_adr    (inv_adr),
        .o_inv_ack    (inv_ack),
        .i_ic_hit     (ic_hit),
        .o_ic_adr     (ic_adr),
        .o_ic_wr      (ic_wr),
        .o_ic_line    (ic_line),
        .o_ic_fault   (ic_fault),
        .o_ic_nxt     (ic_nxt),
        .o_ic_invall  (ic_invall),
        .o_ic_invline (ic_invline),
        .o_bus_cyc    (bus_cyc),
        .o_bus_stb    (bus_stb),
        .o_bus_adr    (bus_adr),
        .i_bus_ack    (bus_ack),
        .i_bus_err    (bus_err),
        .i_bus_dat    (bus_dat)
    );

    // One-entry L1 tag model: tag write sets, invalidates clear.
    always @(posedge clk) begin
        if (ic_wr === 1'b1) begin
            m_tag <= ic_adr[63:6];
            m_vld <= 1'b1;
        end else if (ic_invall === 1'b1) begin
            m_vld <= 1'b0;
        end else if (ic_invline === 1'b1 && ic_adr[63:6] == m_tag) begin
            m_vld <= 1'b0;
        end
        if (ic_wr === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    assign ic_hit = m_vld && (ic_adr[63:6] == m_tag);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; fetch_vld = 1'b0; fetch_adr = '0;
        inv_req = 1'b0; inv_all = 1'b0; inv_adr = '0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_dat = '0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst bus_cyc", bus_cyc, 0);
        chk("rst bus_stb", bus_stb, 0);
        chk("rst ic_wr", ic_wr, 0);
        chk("rst ic_line", ic_line, 0);
        chk("rst ic_fault", ic_fault, 0);
        chk("rst ic_adr", ic_adr, 0);
        chk("rst inv_ack", inv_ack, 0);
        tick();
        rst = 1'b0;

        // Miss at 0x1040, zero-wait bus
        fetch_vld = 1'b1; fetch_adr = 64'h1040; bus_ack = 1'b1;
        exp_line = '0;
        @(negedge clk);
        chk("t1 idle rdy", fetch_rdy, 0);
        chk("t1 idle cyc", bus_cyc, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_dat = {4{32'hC0DE0000 | 32'(i)}};
            exp_line[i*128 +: 128] = bus_dat;
            @(negedge clk);
            chk("t1 bus_adr", bus_adr, 64'h1040 + 64'(16*i));
            chk("t1 bus_stb", bus_stb, 1);
            chk("t1 rdy", fetch_rdy, 0);
            tick();
        end
        bus_ack = 1'b0;
        @(negedge clk);
        chk("t1 wr", ic_wr, 1);
        chk("t1 nxt", ic_nxt, 1);
        chk("t1 stb drop", bus_stb, 0);
        chk("t1 line", ic_line, exp_line);
        chk("t1 fault", ic_fault, 0);
        chk("t1 ic_adr", ic_adr, 64'h1040);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t1 settle wr", ic_wr, 0);
            chk("t1 settle adr", ic_adr, 64'h1040);
            chk("t1 settle rdy", fetch_rdy, 0);
            tick();
        end
        @(negedge clk);
        chk("t1 rdy latency", fetch_rdy, 1);
        chk("t1 wr count", wr_cnt, 1);
        tick();

        // Hit in same line
        fetch_adr = 64'h1058;
        @(negedge clk);
        chk("t2 hit rdy", fetch_rdy, 1);
        chk("t2 hit cyc", bus_cyc, 0);
        tick();
        @(negedge clk);
        chk("t2 hit cyc next", bus_cyc, 0);
        tick();

        // Bus error on beat 2, ack asserted with it
        fetch_adr = 64'h3010; bus_ack = 1'b1;
        exp_line = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus_dat = {4{32'hBAD00000 | 32'(i)}};
            if (i < 2) exp_line[i*128 +: 128] = bus_dat;
            bus_err = (i == 2);
            @(negedge clk);
            chk("t3 bus_adr", bus_adr, 64'h3000 + 64'(16*i));
            tick();
        end
        bus_ack = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        chk("t3 wr", ic_wr, 1);
        chk("t3 fault", ic_fault, 1);
        chk("t3 line", ic_line, exp_line);
        chk("t3 ic_adr", ic_adr, 64'h3000);
        repeat (3) tick();
        @(negedge clk);
        chk("t3 rdy", fetch_rdy, 1);
        chk("t3 fault held", ic_fault, 1);
        chk("t3 wr count", wr_cnt, 2);
        tick();

        // Invalidate takes priority over pending miss
        fetch_adr = 64'h4000;
        inv_req = 1'b1; inv_all = 1'b0; inv_adr = 64'h2000;
        @(negedge clk);
        chk("t4 idle rdy", fetch_rdy, 0);
        chk("t4 idle cyc", bus_cyc, 0);
        tick();
        @(negedge clk);
        chk("t4 invline", ic_invline, 1);
        chk("t4 invall", ic_invall, 0);
        chk("t4 inv_ack", inv_ack, 1);
        chk("t4 inv adr", ic_adr, 64'h2000);
        chk("t4 inv cyc", bus_cyc, 0);
        inv_req = 1'b0;
        tick();
        @(negedge clk);
        chk("t4 ack pulse", inv_ack, 0);
        chk("t4 miss adr", ic_adr, 64'h4000);
        bus_ack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_dat = {4{32'h44440000 | 32'(i)}};
            if (i == 1) fetch_adr = 64'h7000;
            @(negedge clk);
            chk("t4 bus_adr", bus_adr, 64'h4000 + 64'(16*i));
            tick();
        end
        bus_ack = 1'b0;
        @(negedge clk);
        chk("t4 wr", ic_wr, 1);
        chk("t4 wr adr", ic_adr, 64'h4000);
        repeat (3) tick();
        chk("t4 wr count", wr_cnt, 3);

        // Reset mid-fill
        fetch_adr = 64'h5000; bus_ack = 1'b1;
        repeat (3) tick();
        rst = 1'b1; bus_ack = 1'b0;
        @(negedge clk);
        chk("t5 pre cyc", bus_cyc, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5 cyc drop", bus_cyc, 0);
        chk("t5 stb drop", bus_stb, 0);
        chk("t5 line clr", ic_line, 0);
        fetch_adr = 64'h4000;
        #1;
        chk("t5 idle rdy", fetch_rdy, 1);
        fetch_vld = 1'b0;
        repeat (3) tick();
        chk("t5 wr count", wr_cnt, 3);

        // Stalled bus
        fetch_vld = 1'b1; fetch_adr = 64'h6000;
        tick();
`ifdef ANY1_IFILL_TMO_EN
        repeat (254) tick();
        @(negedge clk);
        chk("t6 stb before tmo", bus_stb, 1);
        chk("t6 wr before tmo", ic_wr, 0);
        tick();
        @(negedge clk);
        chk("t6 tmo wr", ic_wr, 1);
        chk("t6 tmo fault", ic_fault, 2);
        chk("t6 tmo line", ic_line, 0);
`else
        repeat (300) tick();
        @(negedge clk);
        chk("t6 stb held", bus_stb, 1);
        chk("t6 adr held", bus_adr, 64'h6000);
        chk("t6 wr none", ic_wr, 0);
        bus_ack = 1'b1;
        repeat (4) tick();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("t6 late wr", ic_wr, 1);
        chk("t6 late fault", ic_fault, 0);
`endif
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
